// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg: shared widths, limits and types for the writeback arbiter and scoreboard
package reg_writeback_pkg;
  localparam int REG_IDX_W = 4;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 16;
  localparam int PEND_W = 2;
  localparam int STARVE_MAX = 3;
  localparam int STARVE_W = 2;
  localparam logic [REG_IDX_W-1:0] PC_REG = 4'd15;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/reg_writeback_wb_scoreboard.sv
// wb_scoreboard: per-register outstanding-write counters, issue/retire update, hazard busy flags, sticky underflow error (busy masking under WB_BYPASS_EN)
module wb_scoreboard
  import reg_writeback_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     issue_valid,
  input  reg_idx_t issue_reg,
  output logic     issue_ready,
  input  logic     retire_en,
  input  reg_idx_t retire_reg,
  input  reg_idx_t chk_regA,
  input  reg_idx_t chk_regB,
  output logic     busyA,
  output logic     busyB,
  output logic     sb_err
);
  logic [PEND_W-1:0] r_cnt [NUM_REGS];
  logic r_sb_err;
  logic w_issue;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  // A full counter can still take an issue when the same register retires this cycle.
  assign issue_ready = r_cnt[issue_reg] != PEND_MAX || (retire_en && retire_reg == issue_reg);
  assign w_issue = issue_valid && issue_ready;
  assign w_inc = {{(NUM_REGS-1){1'b0}}, w_issue} << issue_reg;
  assign w_dec = {{(NUM_REGS-1){1'b0}}, retire_en} << retire_reg;
`ifdef WB_BYPASS_EN
  // The last pending write being retired right now is forwarded by decode, so it is not a hazard.
  assign busyA = r_cnt[chk_regA] != '0 && !(retire_en && retire_reg == chk_regA && r_cnt[chk_regA] == PEND_W'(1));
  assign busyB = r_cnt[chk_regB] != '0 && !(retire_en && retire_reg == chk_regB && r_cnt[chk_regB] == PEND_W'(1));
`else
  assign busyA = r_cnt[chk_regA] != '0;
  assign busyB = r_cnt[chk_regB] != '0;
`endif
  assign sb_err = r_sb_err;
  // Counter update: issue increments, retire decrements, both together cancel; zero never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_REGS; n++) r_cnt[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_REGS; n++)
        if (w_inc[n] && !w_dec[n]) r_cnt[n] <= r_cnt[n] + 1'b1;
        else if (w_dec[n] && !w_inc[n] && r_cnt[n] != '0) r_cnt[n] <= r_cnt[n] - 1'b1;
    end
  end
  // A retire against an empty counter means the pipeline lost track of a write; hold the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sb_err <= 1'b0;
    else if (retire_en && r_cnt[retire_reg] == '0) r_sb_err <= 1'b1;
  end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: load/ALU writeback arbiter with anti-starvation, registered regfile write port and RAW scoreboard (optional WB_BYPASS_EN busy masking)
module reg_writeback
  import reg_writeback_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     issue_valid,
  input  reg_idx_t issue_reg,
  output logic     issue_ready,
  input  logic     alu_valid,
  input  reg_idx_t alu_reg,
  input  data_t    alu_data,
  output logic     alu_ready,
  input  logic     ld_valid,
  input  reg_idx_t ld_reg,
  input  data_t    ld_data,
  output logic     ld_ready,
  output logic     write_en,
  output reg_idx_t write_reg,
  output data_t    write_data,
  input  reg_idx_t chk_regA,
  input  reg_idx_t chk_regB,
  output logic     busyA,
  output logic     busyB,
  output logic     sb_err
);
  logic [STARVE_W-1:0] r_starve;
  logic w_alu_force;
  logic w_ld_win;
  logic w_alu_xfer;
  assign w_alu_force = alu_valid && r_starve == STARVE_W'(STARVE_MAX);
  assign w_ld_win = ld_valid && !w_alu_force;
  assign ld_ready = w_ld_win;
  assign alu_ready = !w_ld_win;
  assign w_alu_xfer = alu_valid && alu_ready;
  // Count consecutive ALU losses so the load port cannot lock the ALU out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_starve <= '0;
    else if (!alu_valid || w_alu_xfer) r_starve <= '0;
    else if (r_starve != STARVE_W'(STARVE_MAX)) r_starve <= r_starve + 1'b1;
  end
  // Register the winning result onto the regfile write port for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_en <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
    end else begin
      write_en <= w_ld_win || w_alu_xfer;
      if (w_ld_win || w_alu_xfer) begin
        write_reg <= w_ld_win ? ld_reg : alu_reg;
        write_data <= w_ld_win ? ld_data : alu_data;
      end
    end
  end
  wb_scoreboard u_sb (
    .clk(clk),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_reg(issue_reg),
    .issue_ready(issue_ready),
    .retire_en(write_en),
    .retire_reg(write_reg),
    .chk_regA(chk_regA),
    .chk_regB(chk_regB),
    .busyA(busyA),
    .busyB(busyB),
    .sb_err(sb_err)
  );
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed vectors with a write-port scoreboard queue and a negedge monitor
module tb_reg_writeback;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic iv, av, lv;
  logic [3:0] ir, ar, lr, ca, cb;
  logic [31:0] ad, ld;
  logic issue_ready, alu_ready, ld_ready, write_en, busyA, busyB, sb_err;
  logic [3:0] write_reg;
  logic [31:0] write_data;
  logic [35:0] q[$];
  logic [35:0] e;
  logic [6:0] exp_ld = 7'b0110111;
  int checks = 0;
  int errors = 0;
  int li, ai;
  always #5 clk = ~clk;
  reg_writeback dut (
    .clk(clk), .reset(reset),
    .issue_valid(iv), .issue_reg(ir), .issue_ready(issue_ready),
    .alu_valid(av), .alu_reg(ar), .alu_data(ad), .alu_ready(alu_ready),
    .ld_valid(lv), .ld_reg(lr), .ld_data(ld), .ld_ready(ld_ready),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .chk_regA(ca), .chk_regB(cb), .busyA(busyA), .busyB(busyB), .sb_err(sb_err)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] r, input logic [31:0] d);
    q.push_back({r, d});
  endtask
  task automatic issue(input logic [3:0] r);
    iv = 1'b1;
    ir = r;
    tick;
    iv = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!reset && write_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got reg %0d data %h expected no write", write_reg, write_data);
      end else begin
        e = q.pop_front();
        chk("write_reg", 32'(write_reg), 32'(e[35:32]));
        chk("write_data", write_data, e[31:0]);
      end
    end
  end
  initial begin
    {iv, av, lv, ir, ar, lr, ca, cb, ad, ld} = '0;
    repeat (2) @(negedge clk);
    chk1("rst_write_en", write_en, 1'b0);
    chk("rst_write_reg", 32'(write_reg), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk1("rst_sb_err", sb_err, 1'b0);
    chk1("rst_busyA", busyA, 1'b0);
    tick;
    reset = 1'b0;
    iv = 1'b1; ir = 4'd3; ca = 4'd3;
    @(negedge clk);
    chk1("t1_issue_ready", issue_ready, 1'b1);
    chk1("t1_busy_before_issue", busyA, 1'b0);
    tick;
    iv = 1'b0; av = 1'b1; ar = 4'd3; ad = 32'hDEADBEEF;
    push(4'd3, 32'hDEADBEEF);
    @(negedge clk);
    chk1("t1_alu_ready", alu_ready, 1'b1);
    chk1("t1_ld_ready", ld_ready, 1'b0);
    chk1("t1_busy_cycN", busyA, 1'b1);
    tick;
    av = 1'b0;
    @(negedge clk);
    chk1("t1_write_en_N1", write_en, 1'b1);
    chk1("t1_busy_N1", busyA, !BYP);
    tick;
    @(negedge clk);
    chk1("t1_write_en_N2", write_en, 1'b0);
    chk1("t1_busy_N2", busyA, 1'b0);
    tick;
    issue(4'd1);
    issue(4'd2);
    av = 1'b1; ar = 4'd1; ad = 32'h11111111;
    lv = 1'b1; lr = 4'd2; ld = 32'h22222222;
    push(4'd2, 32'h22222222);
    @(negedge clk);
    chk1("t2_ld_ready", ld_ready, 1'b1);
    chk1("t2_alu_ready", alu_ready, 1'b0);
    tick;
    lv = 1'b0;
    push(4'd1, 32'h11111111);
    @(negedge clk);
    chk1("t2_alu_ready_next", alu_ready, 1'b1);
    tick;
    av = 1'b0;
    tick;
    issue(4'd8); issue(4'd8);
    for (int r = 9; r <= 13; r++) issue(4'(r));
    li = 9;
    ai = 1;
    for (int k = 0; k < 7; k++) begin
      lv = k < 6; lr = 4'(li); ld = 32'h90000000 + 32'(li);
      av = 1'b1; ar = 4'd8; ad = 32'h80000000 + 32'(ai);
      if (exp_ld[k]) begin
        push(4'(li), 32'h90000000 + 32'(li));
        li++;
      end else begin
        push(4'd8, 32'h80000000 + 32'(ai));
        ai++;
      end
      @(negedge clk);
      chk1($sformatf("t3_ld_ready_k%0d", k), ld_ready, exp_ld[k]);
      chk1($sformatf("t3_alu_ready_k%0d", k), alu_ready, !exp_ld[k]);
      tick;
    end
    av = 1'b0; lv = 1'b0;
    tick;
    tick;
    issue(4'd5); issue(4'd5); issue(4'd5);
    iv = 1'b1; ir = 4'd5; ca = 4'd5;
    av = 1'b1; ar = 4'd5; ad = 32'h55555555;
    push(4'd5, 32'h55555555);
    @(negedge clk);
    chk1("t4_issue_ready_full", issue_ready, 1'b0);
    chk1("t4_alu_ready", alu_ready, 1'b1);
    tick;
    av = 1'b0;
    @(negedge clk);
    chk1("t4_issue_ready_retire", issue_ready, 1'b1);
    tick;
    @(negedge clk);
    chk1("t4_issue_ready_still_full", issue_ready, 1'b0);
    chk1("t4_busy_r5", busyA, 1'b1);
    iv = 1'b0;
    tick;
    ca = 4'd7; av = 1'b1; ar = 4'd7; ad = 32'h77777777;
    push(4'd7, 32'h77777777);
    @(negedge clk);
    chk1("t5_sb_err_before", sb_err, 1'b0);
    tick;
    av = 1'b0;
    @(negedge clk);
    chk1("t5_sb_err_during", sb_err, 1'b0);
    tick;
    ir = 4'd7;
    @(negedge clk);
    chk1("t5_sb_err_set", sb_err, 1'b1);
    chk1("t5_busy_r7", busyA, 1'b0);
    chk1("t5_issue_ready_r7", issue_ready, 1'b1);
    tick;
    tick;
    @(negedge clk);
    chk1("t5_sb_err_held", sb_err, 1'b1);
    tick;
    issue(4'd4);
    ca = 4'd4; av = 1'b1; ar = 4'd4; ad = 32'h44444444;
    push(4'd4, 32'h44444444);
    tick;
    ar = 4'd6; ad = 32'h66666666;
    @(negedge clk);
    chk1("t6_write_en_before", write_en, 1'b1);
    chk1("t6_busy_r4_writing", busyA, !BYP);
    #2 reset = 1'b1;
    #1;
    chk1("t6_write_en_reset", write_en, 1'b0);
    chk1("t6_busy_r4_reset", busyA, 1'b0);
    ca = 4'd5; cb = 4'd8;
    #1;
    chk1("t6_busyA_r5_reset", busyA, 1'b0);
    chk1("t6_busyB_r8_reset", busyB, 1'b0);
    chk1("t6_sb_err_reset", sb_err, 1'b0);
    av = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    @(negedge clk);
    chk1("t6_no_write_after_reset", write_en, 1'b0);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
